// File: rtl/chebyshev_recurrence.sv
// Chebyshev polynomial generator: streams T_0(x) .. T_n(x) in fixed point using
// T_{k+1} = 2*x*T_k - T_{k-1}, one word per EMIT/STEP pair, with valid/ready on both sides.
module chebyshev_recurrence #(
  parameter int unsigned WL     = 16,
  parameter int unsigned I_BITS = 6,
  parameter int unsigned N_MAX  = 15,
  parameter int unsigned DEG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WL-1:0]    x_in_i,
  input  logic [DEG_W-1:0] deg_in_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WL-1:0]    out_data_o,
  output logic [DEG_W-1:0] out_index_o,
  output logic             out_last_o
);

  localparam int unsigned F = WL - I_BITS;

  typedef enum logic [1:0] {StIdle, StEmit, StStep} state_e;

  state_e           state_q, state_d;
  logic [WL-1:0]    x_q, x_d;
  logic [DEG_W-1:0] n_q, n_d;
  logic [DEG_W-1:0] k_q, k_d;
  logic [WL-1:0]    t_cur_q, t_cur_d;
  logic [WL-1:0]    t_prev_q, t_prev_d;

  logic             accept;
  logic             emit_hs;
  logic [DEG_W-1:0] deg_clamped;

  logic signed [2*WL:0] x_ext;
  logic signed [2*WL:0] t_ext;
  logic signed [2*WL:0] prod;
  logic [WL-1:0]        prod_shift;
  logic [WL-1:0]        t_next;

  assign accept  = in_valid_i && (state_q == StIdle);
  assign emit_hs = out_ready_i && (state_q == StEmit);

  // Degrees beyond the supported maximum are clamped rather than rejected.
  assign deg_clamped = (deg_in_i > DEG_W'(N_MAX)) ? DEG_W'(N_MAX) : deg_in_i;

  // Full-precision 2*x*T_cur, then floor shift back to the Q format; the
  // subtraction wraps modulo 2^WL and saturation is left to the consumer.
  assign x_ext      = {{(WL+1){x_q[WL-1]}}, x_q};
  assign t_ext      = {{(WL+1){t_cur_q[WL-1]}}, t_cur_q};
  assign prod       = (x_ext * t_ext) <<< 1;
  assign prod_shift = WL'(prod >>> F);
  assign t_next     = (k_q == '0) ? x_q : (prod_shift - t_prev_q);

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    n_d      = n_q;
    k_d      = k_q;
    t_cur_d  = t_cur_q;
    t_prev_d = t_prev_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          x_d      = x_in_i;
          n_d      = deg_clamped;
          k_d      = '0;
          t_cur_d  = WL'(1) << F;
          t_prev_d = '0;
          state_d  = StEmit;
        end
      end
      StEmit: begin
        if (emit_hs) begin
          state_d = (k_q == n_q) ? StIdle : StStep;
        end
      end
      StStep: begin
        t_prev_d = t_cur_q;
        t_cur_d  = t_next;
        k_d      = k_q + DEG_W'(1);
        state_d  = StEmit;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      x_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      t_cur_q  <= '0;
      t_prev_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      n_q      <= n_d;
      k_q      <= k_d;
      t_cur_q  <= t_cur_d;
      t_prev_q <= t_prev_d;
    end
  end

  // Outputs are decoded from state; the data fields read zero whenever no word is offered.
  always_comb begin
    in_ready_o  = (state_q == StIdle);
    out_valid_o = (state_q == StEmit);
    out_data_o  = out_valid_o ? t_cur_q : '0;
    out_index_o = out_valid_o ? k_q : '0;
    out_last_o  = out_valid_o && (k_q == n_q);
  end

endmodule

// File: doc/chebyshev_recurrence.md
CHEBYSHEV_RECURRENCE -- requirements
Module: chebyshev_recurrence

Interface
REQ-001 Parameter WL, default 16: word length of x and of every T_k output word, two's complement.
REQ-002 Parameter I_BITS, default 6: integer bits including sign; F = WL - I_BITS fractional bits; 1.0 = 2^F.
REQ-003 Parameter N_MAX, default 15: highest supported polynomial degree.
REQ-004 Parameter DEG_W, default 4: width of the degree and index ports; 2^DEG_W > N_MAX.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  upstream offers x_in and deg_in.
REQ-008 in_ready  output  1  block accepts a new request.
REQ-009 x_in  input  WL  evaluation point x, Q(I_BITS).F.
REQ-010 deg_in  input  DEG_W  highest degree n to generate.
REQ-011 out_valid  output  1  out_data holds T_k(x).
REQ-012 out_ready  input  1  downstream saturation stage consumes the word.
REQ-013 out_data  output  WL  T_k(x), same Q format as x_in, unsaturated; integer-bit pruning is done downstream.
REQ-014 out_index  output  DEG_W  k of the current word.
REQ-015 out_last  output  1  high with the word where k = n.

Function
REQ-016 FSM states: IDLE, EMIT, STEP; encoding is free.
REQ-017 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, latch x and n = min(deg_in, N_MAX); set k=0 and T_cur=2^F; go to EMIT.
REQ-018 in_ready is 1 only in IDLE; a request is never accepted while a sequence is in progress.
REQ-019 EMIT: out_valid=1; out_data=T_cur, out_index=k, out_last=(k==n).
REQ-020 While out_valid && !out_ready, out_data, out_index, and out_last hold stable for any number of cycles.
REQ-021 On a handshake in EMIT with k==n, go to IDLE; in_ready rises in the following cycle.
REQ-022 On a handshake in EMIT with k<n, go to STEP; out_valid=0 in STEP.
REQ-023 STEP, k==0: T_next = x.
REQ-024 STEP, k>=1: P = 2*x*T_cur at full 2*WL+1-bit signed precision; arithmetic shift right by F (floor); T_next = P_shifted - T_prev, truncated to the low WL bits (wrap modulo 2^WL, no saturation).
REQ-025 End of STEP: T_prev<=T_cur, T_cur<=T_next, k<=k+1, go to EMIT. Spacing between consecutive words is exactly one bubble cycle.
REQ-026 Latency: request accepted at cycle c gives T_0 valid at c+1. Handshake of T_k at cycle d gives T_{k+1} valid at d+2.
REQ-027 deg_in=0 produces the single word T_0=2^F with out_last=1.
REQ-028 deg_in>N_MAX is clamped; the sequence ends at k=N_MAX with out_last=1.
REQ-029 in_valid is ignored outside IDLE; x_in and deg_in are sampled only at the accept handshake.

Reset
REQ-030 rst_n low immediately forces IDLE, in_ready=1, out_valid=0, out_data=0, out_index=0, out_last=0, and clears internal x, n, T_cur, T_prev.
REQ-031 Reset mid-sequence abandons the sequence; no further words are output after release.
REQ-032 Reset is released synchronously to clk externally; the first accept is possible on the first edge after release.

Verification (WL=16, I_BITS=6, F=10)
REQ-033 Sequence: x_in=0x0200 (0.5), deg_in=3, out_ready=1 -> out_data 0x0400, 0x0200, 0xFE00, 0xFC00; out_index 0..3; out_last only on 0xFC00; words at c+1, c+3, c+5, c+7.
REQ-034 Back-pressure: same stimulus, out_ready=0 for 5 cycles on k=1 -> 0x0200 and index 1 held stable; next word appears 2 cycles after out_ready rises.
REQ-035 Floor and wrap: x_in=0x0001, deg_in=2 -> 0x0400, 0x0001, 0xFC00. x_in=0x1000 (4.0), deg_in=3 -> T_3 = 0xD000 (244 wrapped).
REQ-036 Degenerate and clamp: deg_in=0 -> single 0x0400 with out_last=1. deg_in=15 with N_MAX=15 -> 16 words, last index 15.
REQ-037 Reset mid-run: assert rst_n low during STEP of k=1 -> outputs take reset values immediately; no word after release; a new request is served normally from T_0.
REQ-038 Busy ignore: hold in_valid=1 with changing x_in during a sequence -> only the value at the first accept is used; the next accept occurs only in IDLE.
